vga_nes_upscaler: RTL and testbench

Sits directly downstream of the 1280x1024 VGA timing controller and turns its DrawX/DrawY/blank/hs/vs stream into RGB pixels. The NES picture is 256x240 with 6-bit palette indices. It is scaled 4x in each direction to 1024x960 and centred in the 1280x1024 raster. During each horizontal blank, the block prefetches the next NES line from the frame buffer into a ping-pong line buffer. It then maps palette indices to 24-bit RGB and delays sync/blank to match pixel latency.

---
 rtl/vga_nes_upscaler_if.sv | 10 +
 rtl/vga_nes_upscaler.sv | 195 +++++++++++++++++++
 tb/tb_vga_nes_upscaler.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_nes_upscaler_if.sv
// Frame-buffer read port between the NES upscaler (master) and the frame-buffer memory (slave).
// fb_data carries the palette index for the address presented RD_LATENCY cycles earlier.
interface vga_nes_upscaler_if;
    logic        fb_rd;
    logic [15:0] fb_addr;
    logic [5:0]  fb_data;

    modport master (output fb_rd, output fb_addr, input fb_data);
    modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/vga_nes_upscaler.sv
// Turns a 1280x1024 raster into a centred 4x-scaled 256x240 NES picture: hblank line prefetch
// into a ping-pong line buffer, palette lookup, and sync/blank delayed to the 2-cycle pixel latency.
module vga_nes_upscaler #(
    parameter int H_ACTIVE   = 1280,
    parameter int V_ACTIVE   = 1024,
    parameter int X_OFFSET   = 128,
    parameter int Y_OFFSET   = 32,
    parameter int RD_LATENCY = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [10:0]                DrawX,
    input  logic [10:0]                DrawY,
    input  logic                       blank_in,
    input  logic                       hs_in,
    input  logic                       vs_in,
    vga_nes_upscaler_if.master         fb,
    output logic [7:0]                 red,
    output logic [7:0]                 green,
    output logic [7:0]                 blue,
    output logic                       hs_out,
    output logic                       vs_out,
    output logic                       blank_out,
    output logic                       underrun
);

    localparam int WIN_W = 1024;
    localparam int WIN_H = 960;
    localparam logic [10:0] X_LO  = 11'(X_OFFSET);
    localparam logic [10:0] X_HI  = 11'((X_OFFSET + WIN_W < H_ACTIVE) ? X_OFFSET + WIN_W : H_ACTIVE);
    localparam logic [10:0] Y_LO  = 11'(Y_OFFSET);
    localparam logic [10:0] Y_HI  = 11'((Y_OFFSET + WIN_H < V_ACTIVE) ? Y_OFFSET + WIN_H : V_ACTIVE);
    localparam logic [10:0] H_END = 11'(H_ACTIVE);
    localparam logic [3:0]  DRAIN_LAST = 4'(RD_LATENCY - 1);

    // 2C02 colours, index 0x00..0x3F
    localparam logic [23:0] PALETTE [64] = '{
        24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
        24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
        24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
        24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
        24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
        24'hFFFEFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
        24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
    };

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

    state_t      state_q;
    logic        wr_sel_q;
    logic        fb_rd_q;
    logic [15:0] fb_addr_q;
    logic [7:0]  line_q;
    logic [7:0]  cnt_q;
    logic [3:0]  drain_q;
    logic        underrun_q;

    // The fetch for NES line n runs in the hblank of the physical line just above its first row.
    logic [10:0] y_next;
    logic [9:0]  y_rel;
    logic        trigger;
    logic [7:0]  trig_line;

    assign y_next    = DrawY + 11'd1;
    assign y_rel     = 10'(y_next - Y_LO);
    assign trigger   = (DrawX == H_END) && (y_next >= Y_LO) && (y_next < Y_HI) && (y_rel[1:0] == 2'b00);
    assign trig_line = y_rel[9:2];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            wr_sel_q   <= 1'b0;
            fb_rd_q    <= 1'b0;
            fb_addr_q  <= 16'h0000;
            line_q     <= 8'h00;
            cnt_q      <= 8'h00;
            drain_q    <= 4'h0;
            underrun_q <= 1'b0;
        end else begin
            if (trigger && (state_q != S_IDLE)) begin
                underrun_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (trigger) begin
                        state_q   <= S_FETCH;
                        line_q    <= trig_line;
                        cnt_q     <= 8'h00;
                        fb_rd_q   <= 1'b1;
                        fb_addr_q <= {trig_line, 8'h00};
                    end
                end
                S_FETCH: begin
                    if (cnt_q == 8'hFF) begin
                        fb_rd_q <= 1'b0;
                        drain_q <= 4'h0;
                        state_q <= S_DRAIN;
                    end else begin
                        cnt_q     <= cnt_q + 8'd1;
                        fb_addr_q <= {line_q, cnt_q + 8'd1};
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        wr_sel_q <= ~wr_sel_q;
                        state_q  <= S_IDLE;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fb.fb_rd   = fb_rd_q;
    assign fb.fb_addr = fb_addr_q;
    assign underrun   = underrun_q;

    // Write strobe and column travel alongside the read so they meet the returning fb_data.
    logic       wr_v_q   [RD_LATENCY];
    logic [7:0] wr_idx_q [RD_LATENCY];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                wr_v_q[i] <= 1'b0;
            end
        end else begin
            wr_v_q[0] <= fb_rd_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                wr_v_q[i] <= wr_v_q[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        wr_idx_q[0] <= fb_addr_q[7:0];
        for (int i = 1; i < RD_LATENCY; i++) begin
            wr_idx_q[i] <= wr_idx_q[i-1];
        end
    end

    logic [5:0] lbuf_q [512];
    logic [5:0] pix_idx_q;
    logic [7:0] rd_col;

    assign rd_col = 8'((DrawX - X_LO) >> 2);

    // NOTE: the line buffer is plain storage with no reset; every entry is rewritten before display.
    always_ff @(posedge Clk) begin
        if (wr_v_q[RD_LATENCY-1]) begin
            lbuf_q[{wr_sel_q, wr_idx_q[RD_LATENCY-1]}] <= fb.fb_data;
        end
        pix_idx_q <= lbuf_q[{~wr_sel_q, rd_col}];
    end

    logic        in_win_q;
    logic        blank_q1, blank_q2;
    logic        hs_q1, hs_q2;
    logic        vs_q1, vs_q2;
    logic [23:0] rgb_q;
    logic [23:0] rgb_d;

    assign rgb_d = (in_win_q && blank_q1) ? PALETTE[pix_idx_q] : 24'h000000;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            in_win_q <= 1'b0;
            blank_q1 <= 1'b0;
            blank_q2 <= 1'b0;
            hs_q1    <= 1'b1;
            hs_q2    <= 1'b1;
            vs_q1    <= 1'b1;
            vs_q2    <= 1'b1;
            rgb_q    <= 24'h000000;
        end else begin
            in_win_q <= blank_in && (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
            blank_q1 <= blank_in;
            blank_q2 <= blank_q1;
            hs_q1    <= hs_in;
            hs_q2    <= hs_q1;
            vs_q1    <= vs_in;
            vs_q2    <= vs_q1;
            rgb_q    <= rgb_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign blank_out          = blank_q2;
    assign hs_out             = hs_q2;
    assign vs_out             = vs_q2;

endmodule

// File: tb/tb_vga_nes_upscaler.sv
// Scoreboard bench for vga_nes_upscaler: drives raster segments, models a 2-cycle frame buffer,
// and checks pixel/sync alignment, fetch address sequences, underrun and reset behaviour.
module tb_vga_nes_upscaler;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [10:0] DrawX, DrawY;
    logic        blank_in, hs_in, vs_in;
    logic [7:0]  red, green, blue;
    logic        hs_out, vs_out, blank_out, underrun;

    vga_nes_upscaler_if fb_if ();

    vga_nes_upscaler dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .blank_in  (blank_in),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .fb        (fb_if),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .blank_out (blank_out),
        .underrun  (underrun)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, act, exp);
    endtask

    // Frame-buffer contents: 0 = index from address, 1 = all 0x30, 2 = 0x0F with (line 5, col 10) = 0x16
    int fb_mode = 0;

    function automatic logic [5:0] fb_lookup(input logic [15:0] a);
        if (fb_mode == 0) return a[5:0];
        if (fb_mode == 1) return 6'h30;
        return (a == 16'h050A) ? 6'h16 : 6'h0F;
    endfunction

    function automatic logic [24:0] ref_rgb(input logic [5:0] idx);
        case (idx)
            6'h0F:   return {1'b1, 24'h000000};
            6'h30:   return {1'b1, 24'hFFFEFF};
            6'h16:   return {1'b1, 24'hB53120};
            default: return {1'b0, 24'h000000};
        endcase
    endfunction

    logic [5:0] fb_p1;
    always @(posedge Clk) begin
        fb_p1         <= fb_lookup(fb_if.fb_addr);
        fb_if.fb_data <= fb_p1;
    end

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [26:0] exp;
        logic [26:0] mask;
    } pix_t;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } fa_t;

    pix_t pix_q[$];
    fa_t  addr_q[$];

    bit sb_en        = 1'b0;
    bit addr_mon_en  = 1'b0;
    bit exp_underrun = 1'b0;
    int busy_until   = -1;

    always @(negedge Clk) begin : monitor
        pix_t e;
        fa_t  f;
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            e = pix_q.pop_front();
            check("pixel", {5'b0, {red, green, blue, blank_out, hs_out, vs_out} & e.mask}, {5'b0, e.exp});
        end
        if (addr_mon_en) begin
            if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
                f = addr_q.pop_front();
                check("fb_rd", {31'b0, fb_if.fb_rd}, 32'd1);
                check("fb_addr", {16'b0, fb_if.fb_addr}, {16'b0, f.addr});
            end else if (fb_if.fb_rd) begin
                check("fb_rd_spurious", {31'b0, fb_if.fb_rd}, 32'd0);
            end
        end
    end

    task automatic drive(input int x, input int y);
        pix_t        p;
        logic        bl, hs, vs;
        logic [15:0] a;
        logic [24:0] r;
        fa_t         f;
        int          yn;
        bl = (x < 1280) && (y < 1024);
        hs = !((x >= 1327) && (x < 1439));
        vs = !((y >= 1025) && (y < 1028));
        DrawX    = 11'(x);
        DrawY    = 11'(y);
        blank_in = bl;
        hs_in    = hs;
        vs_in    = vs;
        if (sb_en) begin
            p.due  = cyc + 2;
            p.mask = 27'h7FF_FFFF;
            if (bl && x >= 128 && x < 1152 && y >= 32 && y < 992) begin
                a[15:8] = 8'((y - 32) / 4);
                a[7:0]  = 8'((x - 128) / 4);
                r = ref_rgb(fb_lookup(a));
                p.exp = {r[23:0], bl, hs, vs};
                if (!r[24]) p.mask = 27'h000_0007;
            end else begin
                p.exp = {24'h000000, bl, hs, vs};
            end
            pix_q.push_back(p);
        end
        yn = y + 1;
        if (!Reset && x == 1280 && yn >= 32 && yn < 992 && ((yn - 32) % 4 == 0)) begin
            if (cyc <= busy_until) begin
                exp_underrun = 1'b1;
            end else begin
                for (int k = 0; k < 256; k++) begin
                    f.due  = cyc + 1 + k;
                    f.addr = {8'((yn - 32) / 4), 8'(k)};
                    addr_q.push_back(f);
                end
                busy_until = cyc + 258;
            end
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic line(input int y, input int x0, input int x1);
        for (int x = x0; x <= x1; x++) drive(x, y);
    endtask

    task automatic hblank(input int y);
        line(y, 1270, 1687);
    endtask

    task automatic check_underrun();
        check("underrun", {31'b0, underrun}, {31'b0, exp_underrun});
    endtask

    // Holds Reset for n cycles while the raster keeps moving from (x, y), then checks reset values.
    task automatic do_reset(input int x, input int y, input int n);
        sb_en = 1'b0;
        drive(x, y);
        drive(x + 1, y);
        Reset       = 1'b1;
        addr_mon_en = 1'b0;
        addr_q.delete();
        busy_until  = -1;
        for (int i = 0; i < n; i++) drive(x + 2 + i, y);
        check("rst_fb_rd",    {31'b0, fb_if.fb_rd},       32'd0);
        check("rst_fb_addr",  {16'b0, fb_if.fb_addr},     32'd0);
        check("rst_rgb",      {8'b0, red, green, blue},   32'd0);
        check("rst_hs_out",   {31'b0, hs_out},            32'd1);
        check("rst_vs_out",   {31'b0, vs_out},            32'd1);
        check("rst_blank",    {31'b0, blank_out},         32'd0);
        check("rst_underrun", {31'b0, underrun},          32'd0);
        Reset        = 1'b0;
        exp_underrun = 1'b0;
        addr_mon_en  = 1'b1;
        sb_en        = 1'b1;
    endtask

    initial begin
        Reset    = 1'b1;
        DrawX    = '0;
        DrawY    = '0;
        blank_in = 1'b0;
        hs_in    = 1'b1;
        vs_in    = 1'b1;
        @(posedge Clk);
        #1;
        do_reset(0, 0, 5);

        // Address walk with index = addr[5:0]
        hblank(30);
        hblank(31);
        hblank(35);
        check_underrun();

        // Uniform 0x30 picture: window edges and sync/blank alignment
        fb_mode = 1;
        line(31, 0, 1687);
        line(32, 100, 1687);
        hblank(987);
        line(991, 100, 1200);
        line(992, 100, 1200);
        line(1024, 1660, 1687);
        line(1025, 0, 40);
        line(1027, 1650, 1687);
        line(1028, 0, 10);
        check_underrun();

        // Single coloured NES pixel -> 4x4 block
        fb_mode = 2;
        hblank(51);
        for (int y = 52; y <= 55; y++) line(y, 120, 180);
        hblank(55);
        line(56, 160, 180);

        // Second trigger during a fetch
        fb_mode = 0;
        line(59, 1270, 1350);
        drive(1280, 59);
        line(59, 1351, 1687);
        check_underrun();
        hblank(63);
        check_underrun();

        // Reset in the middle of a fetch, then a clean fetch of NES line 0
        line(67, 1270, 1400);
        do_reset(1401, 67, 5);
        hblank(31);
        check_underrun();

        sb_en = 1'b0;
        line(100, 1270, 1275);
        check("pix_q_left",  pix_q.size(),  32'd0);
        check("addr_q_left", addr_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
